// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and constants for the two-lane word sequencer.
package mem_seq_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;
endpackage

// File: rtl/mem_word_seq.sv
// mem_word_seq: sequences a 16-bit load/store as two byte-lane memory cycles.
module mem_word_seq
    import mem_seq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          IsStore,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] WrData,
    output logic [DW-1:0] RdData,
    output logic          Busy,
    output logic          Done,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          Byte,
    output logic [AW-1:0] DataAddress,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut
);
    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d, dad_q, dad_d;
    logic [DW-1:0] wd_q, wd_d, acc_q, acc_d, rd_q, rd_d, din_q, din_d;
    logic          st_q, st_d, busy_q, busy_d, done_q, done_d;
    logic          mrd_q, mrd_d, mwr_q, mwr_d, byte_q, byte_d, act;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        wd_d    = wd_q;
        st_d    = st_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: if (Start) begin
                state_d = LO;
                a_d     = Addr;
                wd_d    = WrData;
                st_d    = IsStore;
            end
            LO: begin
                state_d = HI;
                acc_d   = st_q ? acc_q : DataOut;
            end
            HI: begin
                state_d = DONE;
                rd_d    = st_q ? rd_q : DataOut;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so the registers present them in that state.
        act    = (state_d == LO) || (state_d == HI);
        mrd_d  = act && !st_d;
        mwr_d  = act && st_d;
        byte_d = (state_d == HI) ? LANE_HI : LANE_LO;
        dad_d  = (state_d == LO) ? a_d : (state_d == HI) ? a_d + AW'(1) : '0;
        din_d  = !act ? '0 : st_d ? wd_d : (state_d == HI) ? acc_d : '0;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            wd_q    <= '0;
            st_q    <= 1'b0;
            acc_q   <= '0;
            rd_q    <= '0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            byte_q  <= LANE_LO;
            dad_q   <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            st_q    <= st_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            byte_q  <= byte_d;
            dad_q   <= dad_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RdData      = rd_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign MemRead     = mrd_q;
    assign MemWrite    = mwr_q;
    assign Byte        = byte_q;
    assign DataAddress = dad_q;
    assign DataIn      = din_q;
endmodule

// File: tb/tb_mem_word_seq.sv
// tb_mem_word_seq: checks mem_word_seq against a byte-lane memory and a word-level model.
module tb_mem_word_seq;
    logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, IsStore = 1'b0;
    logic [7:0]  Addr = '0, DataAddress;
    logic [15:0] WrData = '0, RdData, DataIn, DataOut;
    logic        Busy, Done, MemRead, MemWrite, Byte;
    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  rm [256] = '{default: 8'h00};
    logic [15:0] exp_rd = '0;
    int vecs = 0, errs = 0;

    mem_word_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IsStore(IsStore), .Addr(Addr),
        .WrData(WrData), .RdData(RdData), .Busy(Busy), .Done(Done), .MemRead(MemRead),
        .MemWrite(MemWrite), .Byte(Byte), .DataAddress(DataAddress), .DataIn(DataIn),
        .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    assign DataOut = Byte ? {mem[DataAddress], DataIn[7:0]} : {DataIn[15:8], mem[DataAddress]};
    always @(posedge Clk) if (MemWrite) mem[DataAddress] <= Byte ? DataIn[15:8] : DataIn[7:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic op(input bit st, input logic [7:0] a, input logic [15:0] wd);
        int n;
        logic [7:0] a1;
        a1 = a + 8'd1;
        Start = 1'b1; IsStore = st; Addr = a; WrData = wd;
        n = 0;
        do begin
            @(posedge Clk); #1;
            Start = 1'b0; Addr = 8'($urandom); WrData = 16'($urandom); IsStore = 1'($urandom);
            n++;
            if (n == 1) begin
                chk("lo addr", DataAddress, a);
                chk("lo lane/strobes", {Byte, MemRead, MemWrite}, {1'b0, !st, st});
                chk("lo din", DataIn, st ? wd : 16'h0);
            end
            if (n == 2) begin
                chk("hi addr", DataAddress, a1);
                chk("hi lane/strobes", {Byte, MemRead, MemWrite}, {1'b1, !st, st});
                if (st) chk("hi din", DataIn, wd);
            end
        end while (!Done && n < 10);
        chk("done latency", n, 3);
        chk("done idle outputs", {MemRead, MemWrite, Byte, DataAddress, DataIn, Busy}, {3'b0, 8'h0, 16'h0, 1'b1});
        if (st) begin
            rm[a] = wd[7:0];
            rm[a1] = wd[15:8];
        end else exp_rd = {rm[a1], rm[a]};
        chk("rddata", RdData, exp_rd);
        chk("mem lo byte", mem[a], rm[a]);
        chk("mem hi byte", mem[a1], rm[a1]);
        @(posedge Clk); #1;
        chk("done pulse", {Done, Busy}, 2'b00);
    endtask

    typedef struct {bit st; logic [7:0] a; logic [15:0] wd; logic [15:0] rd;} vec_t;
    vec_t tv [6];

    initial begin
        int dn, bz;
        tv[0] = '{1'b0, 8'h40, 16'h0000, 16'h0000};
        tv[1] = '{1'b1, 8'h40, 16'hA5A5, 16'h0000};
        tv[2] = '{1'b1, 8'h10, 16'hBEEF, 16'h0000};
        tv[3] = '{1'b0, 8'h10, 16'h0000, 16'hBEEF};
        tv[4] = '{1'b1, 8'hFF, 16'h1234, 16'hBEEF};
        tv[5] = '{1'b0, 8'hFF, 16'h0000, 16'h1234};
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        #1; Reset = 1'b0; Start = 1'b0;
        chk("reset outputs", {Busy, Done, MemRead, MemWrite, Byte, DataAddress, DataIn, RdData},
            {5'b0, 8'h0, 16'h0, 16'h0});
        @(posedge Clk); #1;
        chk("reset beats start", Busy, 1'b0);
        foreach (tv[i]) begin
            op(tv[i].st, tv[i].a, tv[i].wd);
            chk($sformatf("table rd %0d", i), RdData, tv[i].rd);
        end
        chk("mem 10", mem[8'h10], 8'hEF);
        chk("mem 11", mem[8'h11], 8'hBE);
        chk("mem ff", mem[8'hFF], 8'h34);
        chk("mem 00", mem[8'h00], 8'h12);
        // Start held high: only the IDLE cycles may accept it.
        Start = 1'b1; IsStore = 1'b0; Addr = 8'h10;
        dn = 0; bz = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            dn += int'(Done);
            bz += int'(Busy);
        end
        Start = 1'b0;
        chk("held start ops", dn, 2);
        chk("held start busy", bz, 6);
        repeat (3) @(posedge Clk); #1;
        // Abort a store during its high-byte cycle.
        Start = 1'b1; IsStore = 1'b1; Addr = 8'h20; WrData = 16'hC3D4;
        @(posedge Clk); #1; Start = 1'b0;
        @(posedge Clk); #1;
        chk("abort in hi", {Byte, MemWrite}, 2'b11);
        Reset = 1'b1;
        @(posedge Clk); #1; Reset = 1'b0;
        rm[8'h20] = 8'hD4; rm[8'h21] = 8'hC3;
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            chk("abort quiet", {Done, Busy, MemWrite, MemRead, RdData}, 20'h0);
            @(posedge Clk); #1;
        end
        exp_rd = 16'h0;
        chk("abort mem 20", mem[8'h20], rm[8'h20]);
        chk("abort mem 21", mem[8'h21], rm[8'h21]);
        for (int k = 0; k < 40; k++)
            op(1'($urandom), 8'($urandom_range(0, 7) == 0 ? 8'hFF : $urandom), 16'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_word_seq.md
MEM_WORD_SEQ -- requirements
Module: mem_word_seq

Interface
REQ-001 Parameter: AW, 8, address width; fixed to match the 256-entry byte memory.
REQ-002 Parameter: DW, 16, word width; two byte lanes, low lane [7:0], high lane [15:8].
REQ-003 Clk  input  1  single clock; all state updates on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request strobe; sampled only in IDLE.
REQ-006 IsStore  input  1  1 = word store, 0 = word load; latched with Start.
REQ-007 Addr  input  AW  byte address of the word's low byte; latched with Start.
REQ-008 WrData  input  DW  store data; latched with Start.
REQ-009 RdData  output  DW  load result; held until the next load completes.
REQ-010 Busy  output  1  high whenever state is not IDLE.
REQ-011 Done  output  1  one-cycle pulse marking completion of the load or store.
REQ-012 MemRead  output  1  memory read enable.
REQ-013 MemWrite  output  1  memory write enable.
REQ-014 Byte  output  1  lane select: 0 = low lane, 1 = high lane.
REQ-015 DataAddress  output  AW  memory byte address.
REQ-016 DataIn  output  DW  memory write data / merge source.
REQ-017 DataOut  input  DW  memory merged read data: Byte=0 gives {DataIn[15:8], mem}; Byte=1 gives {mem, DataIn[7:0]}.

Function
REQ-018 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-019 Transitions:
- IDLE->LO on Start; otherwise stay in IDLE.
- LO->HI, HI->DONE, DONE->IDLE, unconditionally.
REQ-020 Start SHALL be ignored in any state other than IDLE; latched operands SHALL NOT change while Busy.
REQ-021 Memory outputs SHALL be Moore (decoded from state and latched registers only), with no combinational path from Start, Addr or WrData.
REQ-022 IDLE and DONE SHALL drive MemRead=0, MemWrite=0, Byte=0, DataAddress=0, DataIn=0.
REQ-023 LO SHALL drive Byte=0 and DataAddress=A, where A is the latched Addr.
REQ-024 HI SHALL drive Byte=1 and DataAddress=A+1 modulo 256, so A=0xFF wraps the high byte to 0x00.
REQ-025 Store cycles: MemWrite=1, MemRead=0, DataIn=latched WrData in both LO and HI (low byte to A, high byte to A+1, little-endian).
REQ-026 Load LO cycle: MemRead=1, MemWrite=0, DataIn=0; the accumulator SHALL capture DataOut at the LO->HI edge.
REQ-027 Load HI cycle: MemRead=1, MemWrite=0, DataIn=accumulator; RdData SHALL load DataOut at the HI->DONE edge.
REQ-028 Done SHALL be high exactly in DONE; latency from the Start-sampling edge to Done high SHALL be 3 cycles; peak throughput SHALL be one word per 4 cycles.
REQ-029 A store SHALL NOT modify RdData.
REQ-030 Back-to-back operation: Start asserted in the cycle after DONE (state IDLE) SHALL be accepted.

Reset
REQ-031 Reset SHALL force state to IDLE and clear RdData, accumulator, latched Addr, WrData and IsStore to 0; Busy=0 and Done=0 from the following cycle.
REQ-032 Reset SHALL take priority over Start in the same cycle.
REQ-033 Reset mid-operation (LO or HI) SHALL abort with no Done pulse and no further memory strobes after the reset edge.

Structure
REQ-034 Package mem_seq_pkg SHALL hold the state enum typedef (IDLE, LO, HI, DONE), the AW/DW defaults and the lane-select constants LANE_LO=0 and LANE_HI=1.
REQ-035 No sub-module is required; a single FSM module with a registered datapath SHALL be used.

Verification
REQ-036 Bench SHALL instantiate mem_word_seq against the byte-lane data memory, sharing Clk and Reset.
REQ-037 Store WrData=0xBEEF at Addr=0x10, then load 0x10 -> mem[0x10]=0xEF, mem[0x11]=0xBE, RdData=0xBEEF, Done 3 cycles after Start each time.
REQ-038 Store 0x1234 at Addr=0xFF -> mem[0xFF]=0x34, mem[0x00]=0x12; a load from 0xFF returns 0x1234.
REQ-039 Start held high for 8 cycles in IDLE -> exactly 2 operations, Busy high 3 of every 4 cycles, Start ignored while Busy.
REQ-040 Reset asserted during HI of a store to 0x20 -> no Done, state IDLE, MemWrite=0 from the next cycle, RdData=0.
REQ-041 Load from 0x40 after Reset -> RdData=0x0000; then a store of 0xA5A5 -> RdData still 0x0000 (unchanged by the store).
